// File: rtl/sensor_value_solver.sv
// sensor_value_solver: finds the sensor code that makes
// temperature = factotyBaseTemp + factotyTempCoef * tempSensorValue hit targetTemp,
// using a fixed-latency restoring divider behind a start/busy/done handshake.
module sensor_value_solver #(
  parameter int unsigned TEMP_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [TEMP_WIDTH-1:0] targetTemp,
  input  logic [4:0]            factotyBaseTemp,
  input  logic [3:0]            factotyTempCoef,
  output logic                  busy,
  output logic                  done,
  output logic [3:0]            tempSensorValue,
  output logic                  exact,
  output logic                  saturated,
  output logic                  underflow,
  output logic                  coefZero
);

  localparam int unsigned DIFF_W    = TEMP_WIDTH + 1;
  localparam int unsigned CNT_W     = (TEMP_WIDTH > 1) ? $clog2(TEMP_WIDTH) : 1;
  localparam int unsigned REM_W     = 5;
  localparam int unsigned COEF_W    = 4;
  localparam int unsigned VAL_W     = 4;
  localparam int unsigned VAL_MAX   = 15;
  localparam int unsigned LAST_STEP = TEMP_WIDTH - 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  // Dividend bits shift out of the MSB while quotient bits shift in at the LSB.
  logic [TEMP_WIDTH-1:0] quo_q, quo_d;
  logic [REM_W-1:0]    rem_q, rem_d;
  logic [COEF_W-1:0]   coef_q, coef_d;
  // Two's-complement difference; the MSB is the sign.
  logic [DIFF_W-1:0]   diff_q, diff_d;

  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [VAL_W-1:0]    value_q, value_d;
  logic                exact_q, exact_d;
  logic                sat_q, sat_d;
  logic                und_q, und_d;
  logic                cz_q, cz_d;

  logic [DIFF_W-1:0]   diff_c;
  logic [REM_W-1:0]    trial_c;
  logic                fits_c;
  logic [REM_W-1:0]    rem_step_c;
  logic [TEMP_WIDTH-1:0] quo_step_c;
  logic                over_c;

  // Datapath helpers: input difference and one restoring-division step.
  always_comb begin
    diff_c     = DIFF_W'(targetTemp) - DIFF_W'(factotyBaseTemp);
    trial_c    = {rem_q[REM_W-2:0], quo_q[TEMP_WIDTH-1]};
    fits_c     = (trial_c >= REM_W'(coef_q));
    rem_step_c = fits_c ? (trial_c - REM_W'(coef_q)) : trial_c;
    quo_step_c = {quo_q[TEMP_WIDTH-2:0], fits_c};
    over_c     = (quo_q > TEMP_WIDTH'(VAL_MAX));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    coef_d  = coef_q;
    diff_d  = diff_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    value_d = value_q;
    exact_d = exact_q;
    sat_d   = sat_q;
    und_d   = und_q;
    cz_d    = cz_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          diff_d  = diff_c;
          coef_d  = factotyTempCoef;
          quo_d   = diff_c[TEMP_WIDTH-1:0];
          rem_d   = '0;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = S_DIVIDE;
        end
      end

      S_DIVIDE: begin
        if (diff_q[DIFF_W-1]) begin
          // Target below base: no non-negative code reaches it.
          value_d = '0;
          exact_d = 1'b0;
          sat_d   = 1'b0;
          und_d   = 1'b1;
          cz_d    = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else if (coef_q == '0) begin
          // Zero slope: any code yields the base; exact only if target equals it.
          value_d = '0;
          exact_d = (diff_q == '0);
          sat_d   = 1'b0;
          und_d   = 1'b0;
          cz_d    = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          quo_d   = quo_step_c;
          rem_d   = rem_step_c;
          count_d = count_q + CNT_W'(1);
          if (count_q == CNT_W'(LAST_STEP)) begin
            state_d = S_FINISH;
          end
        end
      end

      S_FINISH: begin
        if (over_c) begin
          value_d = VAL_W'(VAL_MAX);
          exact_d = 1'b0;
          sat_d   = 1'b1;
        end else begin
          value_d = quo_q[VAL_W-1:0];
          exact_d = (rem_q == '0);
          sat_d   = 1'b0;
        end
        und_d   = 1'b0;
        cz_d    = 1'b0;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      coef_q  <= '0;
      diff_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      value_q <= '0;
      exact_q <= 1'b0;
      sat_q   <= 1'b0;
      und_q   <= 1'b0;
      cz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      coef_q  <= coef_d;
      diff_q  <= diff_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      value_q <= value_d;
      exact_q <= exact_d;
      sat_q   <= sat_d;
      und_q   <= und_d;
      cz_q    <= cz_d;
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign tempSensorValue = value_q;
  assign exact           = exact_q;
  assign saturated       = sat_q;
  assign underflow       = und_q;
  assign coefZero        = cz_q;

endmodule
